sort_host: RTL

Host-side controller for the bubble-sort accelerator. It accepts an unsorted array on a valid/ready input stream and loads it into the sorter through the sorter's write port. It then runs the start/allDoneFlag handshake and drains the sorted result from the sorter's zero-latency output FIFO onto a valid/ready output stream with a last marker. It sits between the processor/DMA stream fabric and the sorter, and also measures sort duration.

---
 rtl/sort_pkg.sv | 17 +
 rtl/sort_host_if.sv | 25 ++
 rtl/sort_reset_sync.sv | 20 ++
 rtl/sort_host.sv | 107 ++++++++++
 4 files changed

// File: rtl/sort_pkg.sv
// Shared defaults and controller state encoding for the bubble-sort host and its benches.
package sort_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned MAX_LEN = 1024;
    localparam int unsigned CNT_W   = $clog2(MAX_LEN) + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_GAP,
        ST_START,
        ST_RELEASE,
        ST_DRAIN
    } sort_state_t;

endpackage

// File: rtl/sort_host_if.sv
// Stream bundle of sort_host: unsorted input stream (s_*) and sorted output stream (m_*).
interface sort_host_if #(
    parameter int unsigned DATA_W = sort_pkg::DATA_W
);

    logic [DATA_W-1:0] s_data;
    logic              s_valid;
    logic              s_last;
    logic              s_ready;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_last;
    logic              m_ready;

    modport slave (
        input  s_data, s_valid, s_last, m_ready,
        output s_ready, m_data, m_valid, m_last
    );

    modport master (
        output s_data, s_valid, s_last, m_ready,
        input  s_ready, m_data, m_valid, m_last
    );

endinterface

// File: rtl/sort_reset_sync.sv
// Sorter reset: asserts asynchronously with resetn, releases two clocks after resetn rises.
module sort_reset_sync (
    input  logic clock,
    input  logic resetn,
    output logic sort_reset
);

    logic [1:0] stage;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stage <= '1;
        end else begin
            stage <= {stage[0], 1'b0};
        end
    end

    assign sort_reset = stage[1];

endmodule

// File: rtl/sort_host.sv
// Host controller for the bubble-sort accelerator: loads a streamed array, runs the
// start/allDoneFlag handshake, drains the sorted FIFO and measures the sort duration.
module sort_host
    import sort_pkg::*;
(
    input  logic              clock,
    input  logic              resetn,
    sort_host_if.slave        bus,
    output logic              sortReset,
    output logic              writeEnable,
    output logic [DATA_W-1:0] inputArray,
    output logic              start,
    input  logic              allDoneFlag,
    output logic              readEnable,
    input  logic [DATA_W-1:0] SortedArray,
    output logic              busy,
    output logic              done,
    output logic [31:0]       sortCycles
);

    sort_state_t      state, state_next;
    logic [CNT_W-1:0] len, rem, len_inc;
    logic             accept, pop, last_beat;

    sort_reset_sync u_reset_sync (
        .clock     (clock),
        .resetn    (resetn),
        .sort_reset(sortReset)
    );

    // Input is held off while the sorter is still coming out of reset.
    always_comb begin
        len_inc   = (state == ST_IDLE) ? CNT_W'(1) : len + CNT_W'(1);
        accept    = (state == ST_IDLE || state == ST_LOAD) && bus.s_valid && !sortReset;
        pop       = (state == ST_DRAIN) && bus.m_ready;
        last_beat = (rem == CNT_W'(1));
    end

    always_comb begin
        state_next  = state;
        bus.s_ready = 1'b0;
        bus.m_valid = 1'b0;
        bus.m_last  = 1'b0;
        bus.m_data  = '0;
        readEnable  = 1'b0;
        busy        = (state != ST_IDLE);
        case (state)
            ST_IDLE, ST_LOAD: begin
                bus.s_ready = !sortReset;
                if (accept) begin
                    state_next = (bus.s_last || len_inc == CNT_W'(MAX_LEN)) ? ST_GAP : ST_LOAD;
                end
            end
            ST_GAP: state_next = ST_START;
            ST_START: begin
                if (start && allDoneFlag) state_next = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!allDoneFlag) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                bus.m_valid = 1'b1;
                bus.m_data  = SortedArray;
                bus.m_last  = last_beat;
                readEnable  = pop;
                if (pop && last_beat) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            len         <= '0;
            rem         <= '0;
            writeEnable <= 1'b0;
            inputArray  <= '0;
            start       <= 1'b0;
            done        <= 1'b0;
            sortCycles  <= '0;
        end else begin
            state       <= state_next;
            writeEnable <= accept;
            if (accept) begin
                inputArray <= bus.s_data;
                len        <= len_inc;
            end
            // start rises one cycle into START and drops on the edge that samples allDoneFlag.
            start <= (state == ST_START) && !(start && allDoneFlag);
            done  <= pop && last_beat;
            if (state == ST_RELEASE) begin
                rem <= len;
            end else if (pop) begin
                rem <= rem - CNT_W'(1);
            end
            if (state == ST_START) begin
                if (!start) begin
                    sortCycles <= '0;
                end else if (sortCycles != '1) begin
                    sortCycles <= sortCycles + 32'd1;
                end
            end
        end
    end

endmodule
